// File: rtl/disp_defs.sv
// Shared display-path definitions: FSM state encoding, BCD digit width and blank code.
package disp_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int BCD_W = 4;

  // Digit code the display top substitutes for a blanked position.
  localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// Purely combinational; inputs are always <= 9, so the 4-bit result cannot carry out.
module bcd_add3
  import disp_defs::*;
(
  input  logic [BCD_W-1:0] i_dig,
  output logic [BCD_W-1:0] o_dig
);

  assign o_dig = (i_dig >= 4'd5) ? (i_dig + 4'd3) : i_dig;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Define BIN2BCD_LZ_BLANK_EN to drive the leading-zero blank mask; otherwise oBLANK is tied low.
module bin2bcd_seq
  import disp_defs::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iSTART,
  input  logic [BIN_W-1:0]        iBIN,
  output logic                    oBUSY,
  output logic                    oDONE,
  output logic [BCD_W*DIGITS-1:0] oBCD,
  output logic [DIGITS-1:0]       oBLANK
);

  localparam int SCR_W = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BIN_W-1:0]   r_shreg;
  logic [SCR_W-1:0]   r_scr;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCR_W-1:0]   r_bcd;
  logic               r_done;
  logic [SCR_W-1:0]   w_adj;
  logic [SCR_W+BIN_W-1:0] w_shift;
  logic               w_load;
  logic               w_shift_en;
  logic               w_commit;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
        .i_dig (r_scr[BCD_W*g +: BCD_W]),
        .o_dig (w_adj[BCD_W*g +: BCD_W])
      );
    end
  endgenerate

  // Correct every digit first, then shift the whole {scratch, shreg} chain left by one.
  assign w_shift = {w_adj, r_shreg} << 1;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift_en  = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (iSTART) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift_en = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_commit    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_commit;
      if (w_load) begin
        r_shreg <= iBIN;
        r_scr   <= '0;
        r_cnt   <= CNT_W'(BIN_W);
      end else if (w_shift_en) begin
        r_scr   <= w_shift[SCR_W+BIN_W-1:BIN_W];
        r_shreg <= w_shift[BIN_W-1:0];
        r_cnt   <= r_cnt - CNT_W'(1);
      end
      if (w_commit) begin
        r_bcd <= r_scr;
      end
    end
  end

  assign oBUSY = (r_state == ST_SHIFT) || (r_state == ST_DONE);
  assign oDONE = r_done;
  assign oBCD  = r_bcd;

`ifdef BIN2BCD_LZ_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank;

  // Walk down from the top digit; a position blanks only while everything above it is zero.
  always_comb begin
    logic w_run;
    w_blank = '0;
    w_run   = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      w_run      = w_run & (r_scr[BCD_W*d +: BCD_W] == '0);
      w_blank[d] = w_run;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_blank <= '0;
    end else if (w_commit) begin
      r_blank <= w_blank;
    end
  end

  assign oBLANK = r_blank;
`else
  assign oBLANK = '0;
`endif

endmodule
